// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Sequencer for multi-cycle EX operations (MUL/DIV/MADD). Hands out
//            start/step/count controls to the iterative datapath, merges its
//            own stall need with ID/EX hazard requests into the pipeline stall
//            vector, and keeps a saturating count of stalled cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              stallreq_ex_i,
  input  logic              mc_req_i,
  input  logic [1:0]        mc_kind_i,
  input  logic              mc_annul_i,
  output logic              mc_start_o,
  output logic              mc_step_o,
  output logic [CNT_W-1:0]  mc_cnt_o,
  output logic              mc_ready_o,
  output logic              mc_busy_o,
  output logic              mc_badkind_o,
  output logic [5:0]        stall_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter preload is latency minus one: the counter reads "remaining - 1".
  localparam logic [CNT_W-1:0]  MUL_INIT  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0]  MADD_INIT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0]  DIV_INIT  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_ONE  = PERF_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX  = '1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic               accept;
  logic               step;
  logic               ready;
  logic               badkind;
  logic               run_stall;
  logic               mc_stall;
  logic [5:0]         stall_vec;

  // Next-state, counter update and per-cycle datapath controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    step      = 1'b0;
    ready     = 1'b0;
    badkind   = 1'b0;
    run_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mc_req_i) begin
          if (mc_kind_i == 2'd3) begin
            badkind = 1'b1;
          end else if (!mc_annul_i) begin
            accept  = 1'b1;
            state_d = S_RUN;
            case (mc_kind_i)
              2'd0:    cnt_d = MUL_INIT;
              2'd1:    cnt_d = DIV_INIT;
              default: cnt_d = MADD_INIT;
            endcase
          end
        end
      end
      S_RUN: begin
        if (mc_annul_i) begin
          // Flush wins over stepping: drop the op without a result.
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          step      = 1'b1;
          run_stall = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      S_DONE: begin
        // EX retires the result this cycle; a new request waits one cycle.
        ready   = !mc_annul_i;
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stall vector merge: EX-level stalls freeze pc..ex, ID hazards freeze pc..id.
  always_comb begin
    mc_stall = accept | run_stall;
    if (stallreq_ex_i || mc_stall) begin
      stall_vec = 6'b001111;
    end else if (stallreq_id_i) begin
      stall_vec = 6'b000111;
    end else begin
      stall_vec = 6'b000000;
    end
  end

  // Saturating stalled-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_vec != 6'b000000) && (stall_cnt_q != PERF_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERF_ONE;
    end
  end

  // State, iteration counter and performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  assign mc_start_o   = accept  & ~rst;
  assign mc_step_o    = step    & ~rst;
  assign mc_ready_o   = ready   & ~rst;
  assign mc_badkind_o = badkind & ~rst;
  assign mc_busy_o    = (state_q != S_IDLE) & ~rst;
  assign mc_cnt_o     = rst ? '0 : cnt_q;
  assign stall_o      = rst ? 6'b000000 : stall_vec;
  assign stall_cnt_o  = rst ? '0 : stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Self-checking bench for mc_ctrl. Stimulus pushes expected
//            start/ready/badkind events into a queue; a negedge monitor pops
//            and compares them whenever the DUT raises one of those pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        mc_req_i;
  logic [1:0]  mc_kind_i;
  logic        mc_annul_i;

  logic        mc_start_o;
  logic        mc_step_o;
  logic [5:0]  mc_cnt_o;
  logic        mc_ready_o;
  logic        mc_busy_o;
  logic        mc_badkind_o;
  logic [5:0]  stall_o;
  logic [31:0] stall_cnt_o;

  logic        d2_start;
  logic        d2_step;
  logic [5:0]  d2_cnt;
  logic        d2_ready;
  logic        d2_busy;
  logic        d2_badkind;
  logic [5:0]  d2_stall;
  logic [3:0]  d2_stall_cnt;

  mc_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .mc_req_i      (mc_req_i),
    .mc_kind_i     (mc_kind_i),
    .mc_annul_i    (mc_annul_i),
    .mc_start_o    (mc_start_o),
    .mc_step_o     (mc_step_o),
    .mc_cnt_o      (mc_cnt_o),
    .mc_ready_o    (mc_ready_o),
    .mc_busy_o     (mc_busy_o),
    .mc_badkind_o  (mc_badkind_o),
    .stall_o       (stall_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // Narrow perf counter instance, shares all inputs, used for saturation.
  mc_ctrl #(.PERF_W(4)) dut2 (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .stallreq_ex_i (stallreq_ex_i),
    .mc_req_i      (mc_req_i),
    .mc_kind_i     (mc_kind_i),
    .mc_annul_i    (mc_annul_i),
    .mc_start_o    (d2_start),
    .mc_step_o     (d2_step),
    .mc_cnt_o      (d2_cnt),
    .mc_ready_o    (d2_ready),
    .mc_busy_o     (d2_busy),
    .mc_badkind_o  (d2_badkind),
    .stall_o       (d2_stall),
    .stall_cnt_o   (d2_stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] EV_START = 3'b100;
  localparam logic [2:0] EV_READY = 3'b010;
  localparam logic [2:0] EV_BAD   = 3'b001;

  typedef struct {
    logic [2:0]  evt;
    int          cyc;
    logic [5:0]  stall;
    logic [63:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask

  task automatic push(input logic [2:0] evt, input int c, input logic [5:0] st, input int sc);
    exp_t e;
    e.evt   = evt;
    e.cyc   = c;
    e.stall = st;
    e.scnt  = 64'(sc);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Event monitor: every start/ready/badkind pulse must match the queue head.
  always @(negedge clk) begin
    if (mc_start_o || mc_ready_o || mc_badkind_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {61'd0, mc_start_o, mc_ready_o, mc_badkind_o}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("evt_kind", {61'd0, mc_start_o, mc_ready_o, mc_badkind_o}, {61'd0, mon_e.evt});
        chk("evt_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("evt_stall", {58'd0, stall_o}, {58'd0, mon_e.stall});
        chk("evt_stall_cnt", {32'd0, stall_cnt_o}, mon_e.scnt);
      end
    end
  end

  // One op: lat step cycles, optional ID stall throughout, optional annul at
  // cycle annul_at (-1 for none). sc_base is the stall count before T0.
  task automatic run_op(input logic [1:0] kind, input int lat, input logic idst,
                        input int annul_at, input int sc_base);
    int   t0;
    logic step_e;
    int   cnt_e;
    logic [5:0] stall_e;
    tick();
    mc_req_i      = 1'b1;
    mc_kind_i     = kind;
    mc_annul_i    = 1'b0;
    stallreq_id_i = idst;
    t0 = cyc;
    push(EV_START, t0, 6'b001111, sc_base);
    if (annul_at < 0) push(EV_READY, t0 + lat + 1, idst ? 6'b000111 : 6'b000000, sc_base + lat + 1);
    for (int k = 0; k <= lat + 1; k++) begin
      if (k > 0) tick();
      mc_annul_i = (k == annul_at);
      smp();
      step_e  = (k >= 1) && (k <= lat) && (k != annul_at);
      cnt_e   = ((k >= 1) && (k <= lat)) ? (lat - k) : 0;
      stall_e = ((k <= lat) && (k != annul_at)) ? 6'b001111 : (idst ? 6'b000111 : 6'b000000);
      chk("step", {63'd0, mc_step_o}, {63'd0, step_e});
      chk("cnt", {58'd0, mc_cnt_o}, 64'(cnt_e));
      chk("stall", {58'd0, stall_o}, {58'd0, stall_e});
      chk("busy", {63'd0, mc_busy_o}, (k >= 1) ? 64'd1 : 64'd0);
      if (k == annul_at) break;
    end
    if (annul_at < 0) begin
      tick();
      mc_req_i      = 1'b0;
      stallreq_id_i = 1'b0;
      smp();
      chk("idle_after_op", {63'd0, mc_busy_o}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    stallreq_id_i = 1'b1;
    stallreq_ex_i = 1'b0;
    mc_req_i      = 1'b1;
    mc_kind_i     = 2'd1;
    mc_annul_i    = 1'b0;

    // Outputs quiet during reset even with active requests.
    smp();
    chk("rst_start", {63'd0, mc_start_o}, 64'd0);
    chk("rst_stall", {58'd0, stall_o}, 64'd0);
    tick();
    rst           = 1'b0;
    mc_req_i      = 1'b0;
    stallreq_id_i = 1'b0;
    smp();
    chk("post_rst_busy", {63'd0, mc_busy_o}, 64'd0);
    chk("post_rst_stall_cnt", {32'd0, stall_cnt_o}, 64'd0);

    run_op(2'd1, 32, 1'b0, -1, 0);   // DIV
    run_op(2'd0, 4,  1'b1, -1, 33);  // MUL under ID stall: 33 + 5 + 1
    run_op(2'd2, 5,  1'b0, -1, 39);  // MADD
    run_op(2'd1, 32, 1'b0, 5,  45);  // DIV annulled at T5
    run_op(2'd0, 4,  1'b0, -1, 50);  // MUL accepted right after annul

    // Illegal kind held for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      mc_req_i  = 1'b1;
      mc_kind_i = 2'd3;
      push(EV_BAD, cyc, 6'b000000, 55);
      smp();
      chk("bad_step", {63'd0, mc_step_o}, 64'd0);
      chk("bad_stall", {58'd0, stall_o}, 64'd0);
      chk("bad_busy", {63'd0, mc_busy_o}, 64'd0);
    end
    tick();
    mc_req_i = 1'b0;
    smp();
    chk("bad_cleared", {63'd0, mc_badkind_o}, 64'd0);

    // Reset at T10 of a DIV.
    tick();
    mc_req_i  = 1'b1;
    mc_kind_i = 2'd1;
    push(EV_START, cyc, 6'b001111, 55);
    for (int i = 1; i < 10; i++) tick();
    tick();
    rst           = 1'b1;
    stallreq_id_i = 1'b1;
    smp();
    chk("rst10_start", {63'd0, mc_start_o}, 64'd0);
    chk("rst10_step", {63'd0, mc_step_o}, 64'd0);
    chk("rst10_cnt", {58'd0, mc_cnt_o}, 64'd0);
    chk("rst10_ready", {63'd0, mc_ready_o}, 64'd0);
    chk("rst10_busy", {63'd0, mc_busy_o}, 64'd0);
    chk("rst10_badkind", {63'd0, mc_badkind_o}, 64'd0);
    chk("rst10_stall", {58'd0, stall_o}, 64'd0);
    chk("rst10_stall_cnt", {32'd0, stall_cnt_o}, 64'd0);
    tick();
    rst           = 1'b0;
    mc_req_i      = 1'b0;
    stallreq_id_i = 1'b0;
    smp();
    chk("rst10_idle", {63'd0, mc_busy_o}, 64'd0);
    chk("rst10_cnt_clear", {32'd0, stall_cnt_o}, 64'd0);
    chk("rst10_cnt_clear_w4", {60'd0, d2_stall_cnt}, 64'd0);

    // 20 ID-stalled cycles, then one EX-stalled cycle.
    for (int i = 0; i < 20; i++) begin
      tick();
      stallreq_id_i = 1'b1;
      smp();
      chk("id_stall", {58'd0, stall_o}, 64'b000111);
    end
    tick();
    stallreq_id_i = 1'b0;
    stallreq_ex_i = 1'b1;
    smp();
    chk("ex_stall", {58'd0, stall_o}, 64'b001111);
    tick();
    stallreq_ex_i = 1'b0;
    smp();
    chk("stall_cnt_21", {32'd0, stall_cnt_o}, 64'd21);
    chk("stall_cnt_sat", {60'd0, d2_stall_cnt}, 64'd15);
    chk("no_stall", {58'd0, stall_o}, 64'd0);

    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
